// File: rtl/pf_types_pkg.sv
// rtl/pf_types_pkg.sv - shared types, widths and helpers for the prefetch memory arbiter
// Contents:
//   pf_arb_state_t  arbiter FSM state (IDLE, I_BUSY, D_BUSY, PF_BUSY)
//   ADDR_WIDTH, LINE_WIDTH, OFFSET_BITS  default bus geometry
//   GNT_*           bit positions of the one-hot grant vector
//   line_align()    clears the intra-line byte offset of an address
package pf_types_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  localparam int GNT_W  = 3;
  localparam int GNT_I  = 0;
  localparam int GNT_D  = 1;
  localparam int GNT_PF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    PF_BUSY = 2'd3
  } pf_arb_state_t;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr,
                                                       input int offset_bits);
    logic [ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask = mask << offset_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pf_mem_arbiter_if.sv
// rtl/pf_mem_arbiter_if.sv - requester and memory-side bundle of the prefetch memory arbiter
// Signals:
//   i_*   I-cache read port      (read, address in; rdata, resp out of the arbiter)
//   d_*   D-cache read/writeback (read, write, address, wdata in; rdata, resp out)
//   pf_*  prefetcher read port   (read, address in; rdata, resp out)
//   mem_* physical memory port   (read, write, address, wdata out; rdata, resp in)
// Modports:
//   slave   arbiter view
//   master  environment view (caches, prefetcher and memory)
interface pf_mem_arbiter_if #(
  parameter int ADDR_WIDTH = pf_types_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = pf_types_pkg::LINE_WIDTH
);

  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pf_read;
  logic [ADDR_WIDTH-1:0] pf_address;
  logic [LINE_WIDTH-1:0] pf_rdata;
  logic                  pf_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    input  pf_read, pf_address,
    output pf_rdata, pf_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    output pf_read, pf_address,
    input  pf_rdata, pf_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/pf_arb_grant.sv
// rtl/pf_arb_grant.sv - combinational priority-plus-age grant for the memory arbiter
// Ports:
//   en        grant evaluation enable (arbiter is idle)
//   i_read    I-cache request
//   d_read    D-cache read request
//   d_write   D-cache writeback request
//   pf_read   prefetch request
//   age       demand grants taken while a prefetch has been waiting
//   grant_oh  one-hot grant, bit positions GNT_I / GNT_D / GNT_PF
module pf_arb_grant
  import pf_types_pkg::*;
#(
  parameter int PF_AGE_MAX = 4,
  parameter int AGE_W      = 3
) (
  input  logic             en,
  input  logic             i_read,
  input  logic             d_read,
  input  logic             d_write,
  input  logic             pf_read,
  input  logic [AGE_W-1:0] age,
  output logic [GNT_W-1:0] grant_oh
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(PF_AGE_MAX);

  // A prefetch that has watched PF_AGE_MAX demand grants go by jumps the
  // queue once; otherwise demand (D before I) always wins over prefetch.
  always_comb begin
    grant_oh = '0;
    if (en) begin
      if (pf_read && (age == AGE_SAT)) begin
        grant_oh[GNT_PF] = 1'b1;
      end else if (d_read || d_write) begin
        grant_oh[GNT_D] = 1'b1;
      end else if (i_read) begin
        grant_oh[GNT_I] = 1'b1;
      end else if (pf_read) begin
        grant_oh[GNT_PF] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pf_mem_arbiter.sv
// rtl/pf_mem_arbiter.sv - single-outstanding cacheline memory arbiter for I-cache, D-cache and prefetcher
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pf_mem_arbiter_if.slave: requester ports (i_*, d_*, pf_*) and the
//        line-wide physical memory port (mem_*)
// Commands are registered one cycle after grant and held until mem_resp.
// Completion pulses are combinational from mem_resp for the current owner;
// read data is forwarded in that cycle and a registered copy is held after.
module pf_mem_arbiter
  import pf_types_pkg::*;
#(
  parameter int ADDR_WIDTH  = pf_types_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH  = pf_types_pkg::LINE_WIDTH,
  parameter int OFFSET_BITS = pf_types_pkg::OFFSET_BITS,
  parameter int PF_AGE_MAX  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pf_mem_arbiter_if.slave bus
);

  localparam int               AGE_W   = $clog2(PF_AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(PF_AGE_MAX);

  pf_arb_state_t         state_q, state_d;
  logic [AGE_W-1:0]      age_q, age_d, age_bump;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [LINE_WIDTH-1:0] pf_rdata_q, pf_rdata_d;
  logic [GNT_W-1:0]      grant_oh;
  logic                  idle;
  logic                  i_resp_w, d_resp_w, pf_resp_w;

  assign idle = (state_q == IDLE);

  pf_arb_grant #(
    .PF_AGE_MAX (PF_AGE_MAX),
    .AGE_W      (AGE_W)
  ) u_grant (
    .en       (idle),
    .i_read   (bus.i_read),
    .d_read   (bus.d_read),
    .d_write  (bus.d_write),
    .pf_read  (bus.pf_read),
    .age      (age_q),
    .grant_oh (grant_oh)
  );

  // Saturating increment used when a demand grant passes over a waiting prefetch.
  assign age_bump = (age_q == AGE_SAT) ? age_q : age_q + AGE_W'(1);

  always_comb begin
    state_d       = state_q;
    age_d         = age_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    pf_rdata_d    = pf_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_oh[GNT_PF]) begin
          state_d       = PF_BUSY;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = line_align(bus.pf_address, OFFSET_BITS);
          age_d         = '0;
        end else if (grant_oh[GNT_D]) begin
          state_d       = D_BUSY;
          mem_read_d    = bus.d_read;
          mem_write_d   = bus.d_write;
          mem_address_d = line_align(bus.d_address, OFFSET_BITS);
          if (bus.d_write) begin
            mem_wdata_d = bus.d_wdata;
          end
          age_d         = bus.pf_read ? age_bump : '0;
        end else if (grant_oh[GNT_I]) begin
          state_d       = I_BUSY;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = line_align(bus.i_address, OFFSET_BITS);
          age_d         = bus.pf_read ? age_bump : '0;
        end else begin
          // No grant: a waiting prefetch keeps its age, otherwise it clears.
          age_d = bus.pf_read ? age_q : '0;
        end
      end
      default: begin
        // Busy: requests are not looked at until the arbiter is idle again.
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          case (state_q)
            I_BUSY:  i_rdata_d  = bus.mem_rdata;
            D_BUSY:  d_rdata_d  = bus.mem_rdata;
            default: pf_rdata_d = bus.mem_rdata;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      age_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      pf_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      age_q         <= age_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      pf_rdata_q    <= pf_rdata_d;
    end
  end

  // Only the current owner sees mem_resp; mem_resp while idle is dropped.
  assign i_resp_w  = (state_q == I_BUSY)  && bus.mem_resp;
  assign d_resp_w  = (state_q == D_BUSY)  && bus.mem_resp;
  assign pf_resp_w = (state_q == PF_BUSY) && bus.mem_resp;

  assign bus.i_resp   = i_resp_w;
  assign bus.d_resp   = d_resp_w;
  assign bus.pf_resp  = pf_resp_w;

  assign bus.i_rdata  = i_resp_w  ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata  = d_resp_w  ? bus.mem_rdata : d_rdata_q;
  assign bus.pf_rdata = pf_resp_w ? bus.mem_rdata : pf_rdata_q;

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_pf_mem_arbiter.sv
// tb/tb_pf_mem_arbiter.sv - directed self-checking bench for pf_mem_arbiter
module tb_pf_mem_arbiter;
  import pf_types_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_W1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_R2 = {8{32'h0123_4567}};
  localparam logic [255:0] PAT_R3 = {16{16'hC3C3}};
  localparam logic [255:0] PAT_3C = {32{8'h3C}};
  localparam logic [255:0] PAT_R4 = {4{64'h1122_3344_5566_7788}};
  localparam logic [255:0] PAT_5A = {32{8'h5A}};

  always #5 clk = ~clk;

  pf_mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

  pf_mem_arbiter #(
    .ADDR_WIDTH  (32),
    .LINE_WIDTH  (256),
    .OFFSET_BITS (5),
    .PF_AGE_MAX  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk_state(input string tag, input pf_arb_state_t exp);
    chk(tag, 256'(dut.state_q), 256'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pf_read    = 1'b0;
    bus.pf_address = '0;
    bus.mem_rdata  = '0;
    bus.mem_resp   = 1'b0;

    // Reset state
    #2;
    chk_state("rst_state", IDLE);
    chk32("rst_age", 32'(dut.age_q), 32'd0);
    chk1("rst_mem_read", bus.mem_read, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chk32("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk1("rst_pf_resp", bus.pf_resp, 1'b0);
    chk("rst_i_rdata", bus.i_rdata, '0);
    chk("rst_pf_rdata", bus.pf_rdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single prefetch
    bus.pf_read    = 1'b1;
    bus.pf_address = 32'h0000_1234;
    cyc(); settle();
    chk_state("pf1_state", PF_BUSY);
    chk1("pf1_mem_read", bus.mem_read, 1'b1);
    chk1("pf1_mem_write", bus.mem_write, 1'b0);
    chk32("pf1_mem_address", bus.mem_address, 32'h0000_1220);
    cyc(); cyc(); cyc();
    bus.mem_rdata = PAT_A5;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("pf1_held_read", bus.mem_read, 1'b1);
    chk1("pf1_pf_resp", bus.pf_resp, 1'b1);
    chk("pf1_pf_rdata", bus.pf_rdata, PAT_A5);
    chk1("pf1_i_resp", bus.i_resp, 1'b0);
    chk1("pf1_d_resp", bus.d_resp, 1'b0);
    cyc();
    bus.mem_resp = 1'b0;
    bus.pf_read  = 1'b0;
    settle();
    chk_state("pf1_back_idle", IDLE);
    chk1("pf1_read_drop", bus.mem_read, 1'b0);
    chk1("pf1_resp_drop", bus.pf_resp, 1'b0);
    chk("pf1_rdata_hold", bus.pf_rdata, PAT_A5);

    // Priority: D write, then I, then PF, one idle cycle between each
    bus.d_write    = 1'b1;
    bus.d_address  = 32'h0000_4047;
    bus.d_wdata    = PAT_W1;
    bus.i_read     = 1'b1;
    bus.i_address  = 32'h0000_80FF;
    bus.pf_read    = 1'b1;
    bus.pf_address = 32'h0000_C010;
    cyc(); settle();
    chk_state("pri_d_state", D_BUSY);
    chk1("pri_d_write", bus.mem_write, 1'b1);
    chk1("pri_d_read", bus.mem_read, 1'b0);
    chk32("pri_d_addr", bus.mem_address, 32'h0000_4040);
    chk("pri_d_wdata", bus.mem_wdata, PAT_W1);
    chk32("pri_d_age", 32'(dut.age_q), 32'd1);
    bus.mem_rdata = PAT_R3;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("pri_d_resp", bus.d_resp, 1'b1);
    chk1("pri_d_i_resp", bus.i_resp, 1'b0);
    chk1("pri_d_pf_resp", bus.pf_resp, 1'b0);
    cyc();
    bus.mem_resp = 1'b0;
    bus.d_write  = 1'b0;
    settle();
    chk_state("pri_gap1", IDLE);
    chk1("pri_gap1_write", bus.mem_write, 1'b0);
    cyc(); settle();
    chk_state("pri_i_state", I_BUSY);
    chk32("pri_i_addr", bus.mem_address, 32'h0000_80E0);
    chk("pri_i_wdata_hold", bus.mem_wdata, PAT_W1);
    chk32("pri_i_age", 32'(dut.age_q), 32'd2);
    bus.mem_rdata = PAT_R2;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("pri_i_resp", bus.i_resp, 1'b1);
    chk("pri_i_rdata", bus.i_rdata, PAT_R2);
    cyc();
    bus.mem_resp = 1'b0;
    bus.i_read   = 1'b0;
    settle();
    chk_state("pri_gap2", IDLE);
    cyc(); settle();
    chk_state("pri_pf_state", PF_BUSY);
    chk32("pri_pf_addr", bus.mem_address, 32'h0000_C000);
    chk32("pri_pf_age", 32'(dut.age_q), 32'd0);
    bus.mem_rdata = PAT_R3;
    bus.mem_resp  = 1'b1;
    settle();
    chk("pri_pf_rdata", bus.pf_rdata, PAT_R3);
    cyc();
    bus.mem_resp = 1'b0;
    bus.pf_read  = 1'b0;
    settle();
    chk_state("pri_end", IDLE);

    // Starvation: continuous D reads while a prefetch waits
    bus.d_read     = 1'b1;
    bus.d_address  = 32'h0000_3000;
    bus.pf_read    = 1'b1;
    bus.pf_address = 32'h0000_2000;
    for (int k = 1; k <= 4; k++) begin
      cyc(); settle();
      chk_state($sformatf("starve_d%0d_state", k), D_BUSY);
      chk32($sformatf("starve_d%0d_age", k), 32'(dut.age_q), 32'(k));
      bus.mem_resp = 1'b1;
      cyc();
      bus.mem_resp = 1'b0;
      settle();
      chk_state($sformatf("starve_d%0d_idle", k), IDLE);
    end
    cyc(); settle();
    chk_state("starve_pf_state", PF_BUSY);
    chk32("starve_pf_addr", bus.mem_address, 32'h0000_2000);
    chk32("starve_pf_age", 32'(dut.age_q), 32'd0);
    chk1("starve_pf_write", bus.mem_write, 1'b0);
    bus.mem_rdata = PAT_3C;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("starve_pf_resp", bus.pf_resp, 1'b1);
    chk1("starve_d_resp", bus.d_resp, 1'b0);
    cyc();
    bus.mem_resp = 1'b0;
    bus.pf_read  = 1'b0;
    bus.d_read   = 1'b0;
    settle();
    chk_state("starve_end", IDLE);
    chk("starve_pf_rdata", bus.pf_rdata, PAT_3C);

    // Withdrawal: I request dropped one cycle after grant
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_5010;
    cyc(); settle();
    chk_state("wd_state", I_BUSY);
    chk32("wd_addr", bus.mem_address, 32'h0000_5000);
    cyc();
    bus.i_read = 1'b0;
    settle();
    chk1("wd_read_held1", bus.mem_read, 1'b1);
    cyc(); settle();
    chk1("wd_read_held2", bus.mem_read, 1'b1);
    bus.mem_rdata = PAT_R4;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("wd_i_resp", bus.i_resp, 1'b1);
    cyc();
    bus.mem_resp = 1'b0;
    settle();
    chk1("wd_i_resp_once", bus.i_resp, 1'b0);
    chk_state("wd_idle", IDLE);
    cyc(); settle();
    chk_state("wd_no_second", IDLE);
    chk1("wd_no_second_read", bus.mem_read, 1'b0);

    // Spurious memory response while idle
    bus.mem_rdata = PAT_5A;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("sp_i_resp", bus.i_resp, 1'b0);
    chk1("sp_d_resp", bus.d_resp, 1'b0);
    chk1("sp_pf_resp", bus.pf_resp, 1'b0);
    chk("sp_i_rdata", bus.i_rdata, PAT_R4);
    chk("sp_pf_rdata", bus.pf_rdata, PAT_3C);
    cyc();
    bus.mem_resp = 1'b0;
    settle();
    chk_state("sp_idle", IDLE);
    chk1("sp_no_cmd", bus.mem_read, 1'b0);

    // Asynchronous reset in the middle of a prefetch
    bus.pf_read    = 1'b1;
    bus.pf_address = 32'h0000_6000;
    cyc(); settle();
    chk_state("ro_busy", PF_BUSY);
    chk1("ro_read", bus.mem_read, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("ro_read_drop", bus.mem_read, 1'b0);
    chk_state("ro_state", IDLE);
    chk32("ro_addr", bus.mem_address, 32'h0);
    bus.pf_read = 1'b0;
    #2;
    rst = 1'b0;
    cyc();
    bus.mem_rdata = PAT_5A;
    bus.mem_resp  = 1'b1;
    settle();
    chk1("ro_late_pf_resp", bus.pf_resp, 1'b0);
    chk1("ro_late_i_resp", bus.i_resp, 1'b0);
    chk1("ro_late_d_resp", bus.d_resp, 1'b0);
    chk("ro_pf_rdata_cleared", bus.pf_rdata, '0);
    cyc();
    bus.mem_resp = 1'b0;
    settle();
    chk_state("ro_end", IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
